// File: rtl/raystore_resp_demux.sv
// raystore_resp_demux: tag-steered return demux into per-lane FWFT FIFOs, 1-cycle write-to-ds_valid latency, no bypass.
// Backpressure: pipe_stall[i] throttles the arbiter once lane i holds DEPTH-PIPE_LAT entries; RS_DEMUX_STATS_EN adds delivered_cnt/peak_occ.

module raystore_resp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            push_dat,
    input  logic                    stall,
    output logic                    out_vld,
    output logic [W-1:0]            out_dat,
    output logic                    drop,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          accept;

    assign out_vld = (count != '0);
    // Storage is never cleared, so gate the head to keep the idle bus at zero.
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign pop     = out_vld && !stall;
    assign full    = (count == CW'(DEPTH));
    // A full lane still accepts when its head leaves in the same cycle.
    assign accept  = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)      count <= count + CW'(1);
            else if (pop && !accept) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_dat;
    end
endmodule

module raystore_resp_demux #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int DEPTH    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_valid,
    input  logic [$clog2(N)-1:0]   pipe_dest,
    input  logic [W-1:0]           pipe_data,
    output logic [N-1:0]           pipe_stall,
    output logic [N-1:0]           ds_valid,
    output logic [N*W-1:0]         ds_data,
    input  logic [N-1:0]           ds_stall,
    output logic                   overflow
`ifdef RS_DEMUX_STATS_EN
    ,
    output logic [N*16-1:0]                     delivered_cnt,
    output logic [N*($clog2(DEPTH)+1)-1:0]      peak_occ
`endif
);
    localparam int DW = $clog2(N);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N-1:0]         lane_drop;
    logic [N-1:0][CW-1:0] lane_cnt;

    for (genvar i = 0; i < N; i++) begin : g_lane
        raystore_resp_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (pipe_valid && (pipe_dest == DW'(i))),
            .push_dat (pipe_data),
            .stall    (ds_stall[i]),
            .out_vld  (ds_valid[i]),
            .out_dat  (ds_data[i*W +: W]),
            .drop     (lane_drop[i]),
            .count    (lane_cnt[i])
        );

        // Leaves PIPE_LAT slots of headroom for reads already in the pipe.
        assign pipe_stall[i] = (lane_cnt[i] >= CW'(DEPTH - PIPE_LAT));

`ifdef RS_DEMUX_STATS_EN
        logic [15:0]   dcnt;
        logic [CW-1:0] peak_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dcnt   <= '0;
                peak_q <= '0;
            end else begin
                if (ds_valid[i] && !ds_stall[i]) dcnt <= dcnt + 16'd1;
                peak_q <= peak_occ[i*CW +: CW];
            end
        end

        assign delivered_cnt[i*16 +: 16] = dcnt;
        assign peak_occ[i*CW +: CW]      = (lane_cnt[i] > peak_q) ? lane_cnt[i] : peak_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            overflow <= 1'b0;
        else if (|lane_drop) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_raystore_resp_demux.sv
// Bench for raystore_resp_demux: vector table, directed corner sequences, and randomized traffic against a queue-based reference.
module tb_raystore_resp_demux;
    localparam int N = 4, W = 32, DEPTH = 8, PIPE_LAT = 3, CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           pipe_valid;
    logic [1:0]     pipe_dest;
    logic [31:0]    pipe_data;
    logic [3:0]     pipe_stall;
    logic [3:0]     ds_valid;
    logic [127:0]   ds_data;
    logic [3:0]     ds_stall;
    logic           overflow;
`ifdef RS_DEMUX_STATS_EN
    logic [63:0]    delivered_cnt;
    logic [15:0]    peak_occ;
`endif

    raystore_resp_demux #(.N(N), .W(W), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_dest  (pipe_dest),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .ds_valid   (ds_valid),
        .ds_data    (ds_data),
        .ds_stall   (ds_stall),
        .overflow   (overflow)
`ifdef RS_DEMUX_STATS_EN
        ,
        .delivered_cnt (delivered_cnt),
        .peak_occ      (peak_occ)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: each lane is an ordered list of queued results.
    logic [31:0] mq [4][$];
    bit          m_ovf;
    int          m_deliv [4];
    int          m_peak  [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_deliv[i] = 0;
            m_peak[i]  = 0;
        end
        m_ovf = 0;
    endtask

    task automatic model_edge();
        bit pop [4];
        bit acc;
        acc = 0;
        for (int i = 0; i < 4; i++) pop[i] = (mq[i].size() > 0) && !ds_stall[i];
        if (pipe_valid) begin
            if (mq[pipe_dest].size() < DEPTH || pop[pipe_dest]) acc = 1;
            else m_ovf = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                void'(mq[i].pop_front());
                m_deliv[i] = (m_deliv[i] + 1) % 65536;
            end
        end
        if (acc) mq[pipe_dest].push_back(pipe_data);
        for (int i = 0; i < 4; i++) if (mq[i].size() > m_peak[i]) m_peak[i] = mq[i].size();
    endtask

    function automatic bit m_stall(input int i);
        return mq[i].size() >= DEPTH - PIPE_LAT;
    endfunction

    task automatic check_model();
        logic [127:0] ed;
        logic [3:0]   ev, es;
        ed = '0; ev = '0; es = '0;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (mq[i].size() != 0);
            if (ev[i]) ed[i*32 +: 32] = mq[i][0];
            es[i] = m_stall(i);
        end
        chk("model_ds_valid", ds_valid, ev);
        chk("model_ds_data", ds_data, ed);
        chk("model_pipe_stall", pipe_stall, es);
        chk("model_overflow", overflow, m_ovf);
`ifdef RS_DEMUX_STATS_EN
        for (int i = 0; i < 4; i++) begin
            chk("model_delivered_cnt", delivered_cnt[i*16 +: 16], 16'(m_deliv[i]));
            chk("model_peak_occ", peak_occ[i*CW +: CW], CW'(m_peak[i]));
        end
`endif
    endtask

    task automatic step(input logic v, input logic [1:0] d, input logic [31:0] dat, input logic [3:0] st);
        pipe_valid = v; pipe_dest = d; pipe_data = dat; ds_stall = st;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    function automatic logic [127:0] pk(input logic [31:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    typedef struct {
        logic         pv;
        logic [1:0]   dest;
        logic [31:0]  data;
        logic [3:0]   stall;
        logic [3:0]   e_valid;
        logic [3:0]   e_pstall;
        logic [127:0] e_data;
        logic         e_ovf;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] vals [8];
    logic [31:0] extra;
    int          n2;
    logic [1:0]  ln;
    logic        v;
    logic [3:0]  st;

    initial begin
        tbl[0] = '{1'b1, 2'd1, 32'hDEADBEEF, 4'b0000, 4'b0010, 4'b0000, pk(0, 0, 32'hDEADBEEF, 0), 1'b0};
        tbl[1] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 1'b0};
        tbl[2] = '{1'b1, 2'd0, 32'h11111111, 4'b0001, 4'b0001, 4'b0000, pk(0, 0, 0, 32'h11111111), 1'b0};
        tbl[3] = '{1'b1, 2'd3, 32'h33333333, 4'b0001, 4'b1001, 4'b0000, pk(32'h33333333, 0, 0, 32'h11111111), 1'b0};
        tbl[4] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 1'b0};
        tbl[5] = '{1'b1, 2'd2, 32'h22222222, 4'b0100, 4'b0100, 4'b0000, pk(0, 32'h22222222, 0, 0), 1'b0};
        tbl[6] = '{1'b1, 2'd2, 32'h2222AAAA, 4'b0100, 4'b0100, 4'b0000, pk(0, 32'h22222222, 0, 0), 1'b0};
        tbl[7] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b0100, 4'b0000, pk(0, 32'h2222AAAA, 0, 0), 1'b0};
        tbl[8] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 1'b0};

        model_clear();
        rst = 1'b0; pipe_valid = 1'b0; pipe_dest = '0; pipe_data = '0; ds_stall = '0;
        #12;
        chk("reset_ds_valid", ds_valid, 4'b0000);
        chk("reset_pipe_stall", pipe_stall, 4'b0000);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_ds_data", ds_data, 128'h0);
        @(negedge clk); rst = 1'b1;

        // Short vector table: single delivery, stall hold, independent lanes.
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].pv, tbl[k].dest, tbl[k].data, tbl[k].stall);
            chk("tbl_ds_valid", ds_valid, tbl[k].e_valid);
            chk("tbl_pipe_stall", pipe_stall, tbl[k].e_pstall);
            chk("tbl_ds_data", ds_data, tbl[k].e_data);
            chk("tbl_overflow", overflow, tbl[k].e_ovf);
        end

        // Backpressure threshold and in-order drain.
        for (int k = 0; k < 8; k++) vals[k] = $urandom;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2'd0, vals[k], 4'b0001);
            chk("thr_pipe_stall0", pipe_stall[0], (k == 4));
        end
        for (int k = 5; k < 8; k++) step(1'b1, 2'd0, vals[k], 4'b0001);
        chk("thr_full_pipe_stall0", pipe_stall[0], 1'b1);
        chk("thr_full_overflow", overflow, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("thr_drain_valid", ds_valid[0], 1'b1);
            chk("thr_drain_data", ds_data[31:0], vals[k]);
            step(1'b0, 2'd0, 32'h0, 4'b0000);
        end
        chk("thr_drained", ds_valid[0], 1'b0);

        // Full lane with simultaneous pop accepts the push.
        for (int k = 0; k < 8; k++) vals[k] = $urandom;
        extra = $urandom;
        for (int k = 0; k < 8; k++) step(1'b1, 2'd1, vals[k], 4'b0010);
        step(1'b1, 2'd1, extra, 4'b0000);
        chk("fullpop_pipe_stall1", pipe_stall[1], 1'b1);
        chk("fullpop_overflow", overflow, 1'b0);
        for (int k = 1; k < 8; k++) begin
            chk("fullpop_drain_data", ds_data[63:32], vals[k]);
            step(1'b0, 2'd0, 32'h0, 4'b0000);
        end
        chk("fullpop_last_data", ds_data[63:32], extra);
        chk("fullpop_last_valid", ds_valid[1], 1'b1);
        step(1'b0, 2'd0, 32'h0, 4'b0000);
        chk("fullpop_drained", ds_valid[1], 1'b0);

        // Overflow: push into a full, stalled lane is dropped.
        for (int k = 0; k < 8; k++) vals[k] = $urandom;
        for (int k = 0; k < 8; k++) step(1'b1, 2'd3, vals[k], 4'b1000);
        chk("ovf_before", overflow, 1'b0);
        step(1'b1, 2'd3, 32'hBAD0BAD0, 4'b1000);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_pipe_stall3", pipe_stall[3], 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("ovf_drain_data", ds_data[127:96], vals[k]);
            step(1'b0, 2'd0, 32'h0, 4'b0000);
        end
        chk("ovf_drained", ds_valid[3], 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Asynchronous reset mid-stream with lane 2 holding 3 entries.
        for (int k = 0; k < 3; k++) step(1'b1, 2'd2, $urandom, 4'b0100);
        chk("rst_pre_valid", ds_valid, 4'b0100);
        pipe_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_clear();
        chk("rst_async_valid", ds_valid, 4'b0000);
        chk("rst_async_pipe_stall", pipe_stall, 4'b0000);
        chk("rst_async_overflow", overflow, 1'b0);
        chk("rst_async_data", ds_data, 128'h0);
        @(negedge clk); rst = 1'b1;
        step(1'b0, 2'd0, 32'h0, 4'b0000);
        chk("rst_lane2_empty", ds_valid[2], 1'b0);

        // Lane independence: lane 2 stalled, others stream and wrap repeatedly.
        n2 = 0;
        for (int c = 0; c < 128; c++) begin
            ln = 2'(c % 4);
            if (ln == 2'd2) begin
                if (n2 < 8) n2++;
                else ln = 2'd0;
            end
            step(1'b1, ln, $urandom, 4'b0100);
            if (ln != 2'd2) chk("indep_next_cycle_valid", ds_valid[ln], 1'b1);
        end
        chk("indep_pipe_stall", pipe_stall, 4'b0100);
        chk("indep_lane2_held", ds_valid[2], 1'b1);
        chk("indep_overflow", overflow, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b0, 2'd0, 32'h0, 4'b0000);
        chk("indep_all_drained", ds_valid, 4'b0000);

        // Randomized traffic, mostly honouring pipe_stall like the arbiter would.
        for (int c = 0; c < 3000; c++) begin
            ln = 2'($urandom_range(0, 3));
            v  = ($urandom_range(0, 3) != 0);
            if (m_stall(ln) && $urandom_range(0, 63) != 0) v = 1'b0;
            st = '0;
            for (int i = 0; i < 4; i++) st[i] = ($urandom_range(0, 9) < 4);
            step(v, ln, $urandom, st);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 2'd0, 32'h0, 4'b0000);
        chk("final_drained", ds_valid, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
